// File: rtl/ccff_loader.sv
// Bitstream loader: double-buffered word-to-serial converter feeding a ccff configuration chain.
// Two-edge latency from word acceptance to first chain_en; stalls hold ccff_head with chain_en low.
module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int SC_W   = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] BITS_TOTAL = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  WORDS_MAX  = WC_W'(NWORDS);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] hold_dat, shift_dat;
  logic              hold_vld;
  logic [SC_W-1:0]   shift_cnt;
  logic [WC_W-1:0]   words_acc;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              begin_load, accept, issue, from_shift, hold_take, last_bit;

  always_comb begin
    begin_load = start && (state != LOAD);
    word_ready = (state == LOAD) && !hold_vld && (words_acc < WORDS_MAX);
    accept     = word_valid && word_ready;
    from_shift = (shift_cnt != '0);
    issue      = (state == LOAD) && (issue_cnt < BITS_TOTAL) && (from_shift || hold_vld);
    // Hold is drained either straight to the head (shift empty) or as a refill behind the last shift bit.
    hold_take  = issue && (!from_shift || (shift_cnt == SC_W'(1) && hold_vld));
    last_bit   = chain_en && (bit_cnt == BITS_TOTAL - CNT_W'(1));
    busy       = (state == LOAD);
    done       = (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (last_bit) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      hold_dat    <= '0;
      hold_vld    <= 1'b0;
      shift_dat   <= '0;
      shift_cnt   <= '0;
      words_acc   <= '0;
      issue_cnt   <= '0;
      bit_cnt     <= '0;
      ccff_head   <= 1'b0;
      chain_en    <= 1'b0;
      tail_parity <= 1'b0;
    end else if (begin_load) begin
      hold_dat    <= '0;
      hold_vld    <= 1'b0;
      shift_dat   <= '0;
      shift_cnt   <= '0;
      words_acc   <= '0;
      issue_cnt   <= '0;
      bit_cnt     <= '0;
      chain_en    <= 1'b0;
      tail_parity <= 1'b0;
    end else begin
      chain_en <= issue;
      if (issue) begin
        ccff_head <= from_shift ? shift_dat[WORD_W-1] : hold_dat[WORD_W-1];
        issue_cnt <= issue_cnt + CNT_W'(1);
      end

      if (issue && from_shift) begin
        if (hold_take) begin
          shift_dat <= hold_dat;
          shift_cnt <= SC_W'(WORD_W);
        end else begin
          shift_dat <= shift_dat << 1;
          shift_cnt <= shift_cnt - SC_W'(1);
        end
      end else if (issue) begin
        shift_dat <= hold_dat << 1;
        shift_cnt <= SC_W'(WORD_W - 1);
      end

      // accept needs an empty hold and hold_take a full one, so they never coincide.
      if (accept) begin
        hold_dat  <= word_in;
        hold_vld  <= 1'b1;
        words_acc <= words_acc + WC_W'(1);
      end else if (hold_take) begin
        hold_vld  <= 1'b0;
      end

      if (chain_en) begin
        tail_parity <= tail_parity ^ ccff_tail;
        if (bit_cnt != BITS_TOTAL) bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule
